qmult_seq: RTL and testbench

- Sequential shift-and-add fixed-point multiplier for the Q-format arithmetic family.
- Data format: sign-magnitude, N bits. MSB is the sign; the low N-1 bits are magnitude with Q fractional bits.
- Counterpart to the iterative divider: takes a start pulse, iterates one multiplier bit per clock, and reports a one-cycle complete strobe.
- Area-cheap alternative to the combinational multiplier where timing is tight.

---
 rtl/qmath_pkg.sv | 27 ++
 rtl/qsat_round.sv | 31 +++
 rtl/qmult_seq.sv | 102 ++++++++++
 tb/tb_qmult_seq.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qmath_pkg.sv
// Shared Q-format definitions: controller state encoding, sign-magnitude field
// constants and pack/unpack helpers for the 32-bit Q-format family.
package qmath_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } qstate_t;

    localparam int QM_N     = 32;
    localparam int QM_Q     = 15;
    localparam int SIGN_IDX = QM_N - 1;
    localparam int MAG_W    = QM_N - 1;

    function automatic logic [QM_N-1:0] sm_pack(input logic sign, input logic [MAG_W-1:0] mag);
        return {sign, mag};
    endfunction

    function automatic logic sm_sign(input logic [QM_N-1:0] word);
        return word[SIGN_IDX];
    endfunction

    function automatic logic [MAG_W-1:0] sm_mag(input logic [QM_N-1:0] word);
        return word[MAG_W-1:0];
    endfunction

endpackage

// File: rtl/qsat_round.sv
// Truncate (or round half up when QMULT_SEQ_ROUND_EN is defined) and saturate a
// Q-format magnitude product into an N-bit sign-magnitude word plus overflow.
module qsat_round #(
    parameter int Q = 15,
    parameter int N = 32
) (
    // Product magnitude bits [2N-3 : Q-1]; bit 0 here is the rounding bit P[Q-1].
    input  logic [2*N-Q-2:0] prod,
    input  logic             sign,
    output logic [N-1:0]     result,
    output logic             overflow
);

`ifdef QMULT_SEQ_ROUND_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    logic [N-1:0] mag_sum;
    logic [N-2:0] mag;

    always_comb begin
        mag_sum  = {1'b0, prod[N-1:1]} + {{(N-1){1'b0}}, ROUND_EN & prod[0]};
        overflow = (|prod[2*N-Q-2:N]) | mag_sum[N-1];
        mag      = overflow ? '1 : mag_sum[N-2:0];
        // A zero magnitude never carries a sign, so -0 cannot escape.
        result   = {sign & (|mag), mag};
    end

endmodule

// File: rtl/qmult_seq.sv
// Sequential shift-and-add sign-magnitude Q-format multiplier, one multiplier
// bit per clock. Optional rounding via QMULT_SEQ_ROUND_EN (see qsat_round).
module qmult_seq
    import qmath_pkg::*;
#(
    parameter int Q = 15,
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         complete,
    output logic [N-1:0] result,
    output logic         overflow
);

    localparam int MW = N - 1;
    localparam int PW = 2 * N - 2;
    localparam int CW = $clog2(N);

    qstate_t         state, state_next;
    logic [PW-1:0]   mcand, acc, acc_next;
    logic [MW-1:0]   mplier;
    logic [CW-1:0]   cnt;
    logic            sign;
    logic            last;
    logic [N-1:0]    sat_result;
    logic            sat_ovf;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        last       = 1'b0;
        acc_next   = acc + (mplier[0] ? mcand : '0);
        case (state)
            IDLE: if (start) state_next = CALC;
            CALC: begin
                busy = 1'b1;
                if (cnt == CW'(1)) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The final iteration's sum goes straight to the saturator so the result
    // registers on the same edge that ends CALC.
    qsat_round #(.Q(Q), .N(N)) u_sat (
        .prod     (acc_next[PW-1:Q-1]),
        .sign     (sign),
        .result   (sat_result),
        .overflow (sat_ovf)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values and ordering between blocks cannot matter.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: datapath registers are reset too; the bench checks outputs
            // right after reset and there are no memories here to exempt.
            state    <= IDLE;
            complete <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
            cnt      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            sign     <= 1'b0;
        end else begin
            state    <= state_next;
            complete <= last;
            case (state)
                IDLE: if (start) begin
                    mcand  <= {{(PW-MW){1'b0}}, a[MW-1:0]};
                    mplier <= b[MW-1:0];
                    sign   <= a[N-1] ^ b[N-1];
                    acc    <= '0;
                    cnt    <= CW'(N - 1);
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    if (last) begin
                        result   <= sat_result;
                        overflow <= sat_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qmult_seq.sv
// Self-checking bench for qmult_seq (Q=15, N=32): scoreboard of expected
// results, checked whenever complete strobes. Honours QMULT_SEQ_ROUND_EN.
module tb_qmult_seq;
    import qmath_pkg::*;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, complete, overflow;
    logic [31:0] result;

    int   vectors = 0;
    int   miscompares = 0;
    int   completes_seen = 0;
    exp_t sb[$];

    qmult_seq #(.Q(15), .N(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .complete (complete),
        .result   (result),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Independent reference: integer product, shift, optional round, range test.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p, m;
        logic [30:0] mag;
        logic        ovf;
        exp_t        e;
        p = {33'b0, sm_mag(x)} * {33'b0, sm_mag(y)};
        m = p >> 15;
`ifdef QMULT_SEQ_ROUND_EN
        m = m + {63'b0, p[14]};
`endif
        ovf   = (m > 64'h7FFF_FFFF);
        mag   = ovf ? 31'h7FFF_FFFF : m[30:0];
        e.res = sm_pack((sm_sign(x) ^ sm_sign(y)) && (mag != 0), mag);
        e.ovf = ovf;
        return e;
    endfunction

    always @(negedge clk) begin
        if (complete === 1'b1) begin
            exp_t e;
            completes_seen++;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_complete: result=%h overflow=%b, no operation pending",
                         result, overflow);
            end else begin
                e = sb.pop_front();
                if (result !== e.res || overflow !== e.ovf) begin
                    miscompares++;
                    $display("FAIL product: result=%h overflow=%b, expected result=%h overflow=%b",
                             result, overflow, e.res, e.ovf);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] x, input logic [31:0] y, input exp_t e);
        @(negedge clk);
        start = 1'b1;
        a     = x;
        b     = y;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (complete === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s_timeout: complete=%b after 100 cycles, expected 1", name, complete);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        a     = 32'h0001_0000;
        b     = 32'h0001_0000;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || complete !== 1'b0 || result !== 32'h0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b complete=%b result=%h overflow=%b, expected all 0",
                     busy, complete, result, overflow);
        end
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_priority: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_timing();
        bit busy_ok = 1'b1;
        exp_t e = '{res: 32'h0001_8000, ovf: 1'b0};
        issue(32'h0000_C000, 32'h0001_0000, e);
        // Now one negedge past the sampling edge: busy must cover 31 cycles.
        for (int k = 1; k <= 31; k++) begin
            if (busy !== 1'b1 || complete !== 1'b0) busy_ok = 1'b0;
            if (k < 31) @(negedge clk);
        end
        vectors++;
        if (!busy_ok) begin
            miscompares++;
            $display("FAIL busy_window: busy/complete wrong in iteration window, expected busy=1 complete=0");
        end
        @(negedge clk);
        vectors++;
        if (complete !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL complete_edge: complete=%b busy=%b, expected 1 0", complete, busy);
        end
        @(negedge clk);
        vectors++;
        if (complete !== 1'b0 || result !== 32'h0001_8000) begin
            miscompares++;
            $display("FAIL strobe_hold: complete=%b result=%h, expected 0 00018000", complete, result);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va[6] = '{32'h8000_C000, 32'h8000_0000, 32'h4000_0000,
                               32'hC000_0000, 32'h7FFF_FFFF, 32'h0000_0001};
        logic [31:0] vb[6] = '{32'h0001_0000, 32'h0000_8000, 32'h0001_0000,
                               32'h0001_0000, 32'h0000_8000, 32'h0000_4000};
        exp_t ve[6];
        ve[0] = '{res: 32'h8001_8000, ovf: 1'b0};
        ve[1] = '{res: 32'h0000_0000, ovf: 1'b0};
        ve[2] = '{res: 32'h7FFF_FFFF, ovf: 1'b1};
        ve[3] = '{res: 32'hFFFF_FFFF, ovf: 1'b1};
        ve[4] = '{res: 32'h7FFF_FFFF, ovf: 1'b0};
`ifdef QMULT_SEQ_ROUND_EN
        ve[5] = '{res: 32'h0000_0001, ovf: 1'b0};
`else
        ve[5] = '{res: 32'h0000_0000, ovf: 1'b0};
`endif
        for (int i = 0; i < 6; i++) begin
            issue(va[i], vb[i], ve[i]);
            wait_done("directed");
        end
    endtask

    task automatic test_random();
        logic [31:0] x, y;
        for (int i = 0; i < 10; i++) begin
            x = $urandom >> $urandom_range(0, 16);
            y = $urandom >> $urandom_range(0, 16);
            x[31] = $urandom_range(0, 1);
            y[31] = $urandom_range(0, 1);
            issue(x, y, model(x, y));
            wait_done("random");
        end
    endtask

    task automatic test_back_to_back();
        exp_t ea = '{res: 32'h0002_0000, ovf: 1'b0};
        exp_t eb = '{res: 32'h8001_8000, ovf: 1'b0};
        issue(32'h0001_0000, 32'h0001_0000, ea);      // returns at n1
        repeat (3) @(negedge clk);                     // n4
        start = 1'b1;
        a     = 32'h0003_0000;
        b     = 32'h0003_0000;
        @(negedge clk);                                // n5
        start = 1'b0;
        repeat (27) @(negedge clk);                    // n32
        vectors++;
        if (complete !== 1'b1) begin
            miscompares++;
            $display("FAIL first_complete: complete=%b at cycle 32, expected 1", complete);
        end
        start = 1'b1;
        a     = 32'h8000_8000;
        b     = 32'h0001_8000;
        sb.push_back(eb);
        @(negedge clk);                                // n33
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || complete !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_busy: busy=%b complete=%b, expected 1 0", busy, complete);
        end
        repeat (30) @(negedge clk);                    // n63
        vectors++;
        if (complete !== 1'b0) begin
            miscompares++;
            $display("FAIL early_complete: complete=%b at cycle 63, expected 0", complete);
        end
        @(negedge clk);                                // n64
        vectors++;
        if (complete !== 1'b1) begin
            miscompares++;
            $display("FAIL second_complete: complete=%b at cycle 64, expected 1", complete);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int seen_before;
        @(negedge clk);
        start = 1'b1;
        a     = 32'h0001_0000;
        b     = 32'h0002_0000;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || complete !== 1'b0 || result !== 32'h0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_state: busy=%b complete=%b result=%h overflow=%b, expected all 0",
                     busy, complete, result, overflow);
        end
        reset       = 1'b0;
        seen_before = completes_seen;
        repeat (40) @(negedge clk);
        vectors++;
        if (completes_seen != seen_before || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_strobe: %0d strobes busy=%b after abort, expected 0 strobes busy=0",
                     completes_seen - seen_before, busy);
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_abort();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
